// File: rtl/fir_stereo_mac.sv
// Time-multiplexed stereo FIR low-pass: one shared signed multiplier and accumulator, left then right.
// Define FIR_SATURATE_EN to clamp results to 24-bit range; otherwise results wrap.
module fir_stereo_mac #(
    parameter int                  NTAPS  = 8,
    parameter int                  CW     = 16,
    parameter logic [NTAPS*CW-1:0] COEFFS = {8{16'sd4096}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic signed [23:0] left_in,
    input  logic signed [23:0] right_in,
    output logic signed [23:0] left_out,
    output logic signed [23:0] right_out,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);
    localparam int DW  = 24;
    localparam int LOG = $clog2(NTAPS);
    localparam int PW  = DW + CW;
    localparam int AW  = PW + LOG;
    localparam logic signed [AW-1:0] RND = AW'(16384);
`ifdef FIR_SATURATE_EN
    localparam logic signed [AW-1:0] SAT_MAX = AW'(2**(DW-1) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - AW'(1);
`endif

    typedef enum logic [1:0] {IDLE, MAC_L, MAC_R, DONE} state_t;

    state_t               r_state;
    logic [LOG-1:0]       r_wptr;
    logic [LOG-1:0]       r_k;
    logic signed [DW-1:0] r_hist_l [NTAPS];
    logic signed [DW-1:0] r_hist_r [NTAPS];
    logic signed [AW-1:0] r_acc;
    logic signed [DW-1:0] r_left_res;
    logic signed [DW-1:0] r_right_res;
    logic signed [DW-1:0] r_left_out;
    logic signed [DW-1:0] r_right_out;
    logic                 r_out_valid;
    logic                 r_busy;
    logic                 r_overrun;

    logic [LOG-1:0]       w_idx;
    logic signed [DW-1:0] w_samp;
    logic signed [CW-1:0] w_coef;
    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_sum;
    logic                 w_last;

    // Round half up, then clamp or wrap to the 24-bit output range.
    function automatic logic signed [DW-1:0] round_sat(input logic signed [AW-1:0] a);
`ifdef FIR_SATURATE_EN
        logic signed [AW-1:0] sh;
        sh = (a + RND) >>> 15;
        if (sh > SAT_MAX) return {1'b0, {(DW-1){1'b1}}};
        if (sh < SAT_MIN) return {1'b1, {(DW-1){1'b0}}};
        return DW'(sh);
`else
        return DW'((a + RND) >>> 15);
`endif
    endfunction

    // Tap k reads the k-th newest sample; the index wraps with the buffer.
    assign w_idx  = r_wptr - r_k;
    assign w_samp = (r_state == MAC_R) ? r_hist_r[w_idx] : r_hist_l[w_idx];
    assign w_coef = COEFFS[r_k*CW +: CW];
    assign w_prod = PW'(w_samp) * PW'(w_coef);
    assign w_sum  = r_acc + AW'(w_prod);
    assign w_last = (r_k == LOG'(NTAPS - 1));

    assign left_out  = r_left_out;
    assign right_out = r_right_out;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

    // busy stays high through the out_valid cycle, so a new sample needs IDLE and !busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wptr      <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_left_res  <= '0;
            r_right_res <= '0;
            r_left_out  <= '0;
            r_right_out <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                r_hist_l[i] <= '0;
                r_hist_r[i] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            if (sample_valid && r_busy) r_overrun <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (sample_valid) begin
                        r_hist_l[r_wptr] <= left_in;
                        r_hist_r[r_wptr] <= right_in;
                        r_acc            <= '0;
                        r_k              <= '0;
                        r_busy           <= 1'b1;
                        r_state          <= MAC_L;
                    end
                end
                MAC_L: begin
                    if (w_last) begin
                        r_left_res <= round_sat(w_sum);
                        r_acc      <= '0;
                        r_k        <= '0;
                        r_state    <= MAC_R;
                    end else begin
                        r_acc <= w_sum;
                        r_k   <= r_k + 1'b1;
                    end
                end
                MAC_R: begin
                    if (w_last) begin
                        r_right_res <= round_sat(w_sum);
                        r_acc       <= '0;
                        r_k         <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_acc <= w_sum;
                        r_k   <= r_k + 1'b1;
                    end
                end
                DONE: begin
                    r_left_out  <= r_left_res;
                    r_right_out <= r_right_res;
                    r_out_valid <= 1'b1;
                    r_wptr      <= r_wptr + 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
